// File: rtl/imem_loader.sv
// Byte-stream program loader: packs a valid/ready byte stream into big-endian 32-bit words,
// writes them to instruction memory at consecutive word addresses, and holds the CPU until done.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024,
  localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  input  logic          byte_last,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_din,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic          cpu_hold,
  output logic [CW-1:0] word_count
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e        state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   word_q, word_d;
  logic [31:0]   word_next;
  logic [CW-1:0] count_q, count_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   din_q, din_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          hold_q, hold_d;
  logic          accept;
  logic          full;

  assign byte_ready = (state_q == StLoad);
  assign busy       = (state_q == StLoad);
  assign accept     = byte_valid && byte_ready;
  assign full       = (count_q == CW'(DEPTH));

  // Drop the incoming byte into its big-endian lane of the word being assembled.
  always_comb begin
    word_next = word_q;
    unique case (lane_q)
      2'd0: word_next[31:24] = byte_data;
      2'd1: word_next[23:16] = byte_data;
      2'd2: word_next[15:8]  = byte_data;
      2'd3: word_next[7:0]   = byte_data;
      default: word_next = word_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          lane_d  = 2'd0;
          word_d  = 32'h0;
          count_d = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      StLoad: begin
        if (accept) begin
          if (full) begin
            ovf_d = 1'b1;
          end else if (lane_q == 2'd3 || byte_last) begin
            // word_q is kept zero above the fill point, so short words come out zero-padded.
            we_d    = 1'b1;
            din_d   = word_next;
            addr_d  = BASE_ADDR + (32'(count_q) << 2);
            count_d = count_q + 1'b1;
            lane_d  = 2'd0;
            word_d  = 32'h0;
          end else begin
            lane_d = lane_q + 2'd1;
            word_d = word_next;
          end
          if (byte_last) begin
            state_d = StDone;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      lane_q  <= 2'd0;
      word_q  <= 32'h0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      din_q   <= 32'h0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      hold_q  <= hold_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign cpu_hold   = hold_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: three instances (default, BASE_ADDR=0x100, DEPTH=2)
// share one input stream; each scenario task checks the instance it targets.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic byte_last = 1'b0;

  logic        rdy_a, we_a, busy_a, done_a, ovf_a, hold_a;
  logic [31:0] addr_a, din_a;
  logic [10:0] wc_a;
  logic        rdy_b, we_b, busy_b, done_b, ovf_b, hold_b;
  logic [31:0] addr_b, din_b;
  logic [10:0] wc_b;
  logic        rdy_c, we_c, busy_c, done_c, ovf_c, hold_c;
  logic [31:0] addr_c, din_c;
  logic [1:0]  wc_c;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [31:0] qa_addr[$], qa_din[$], qb_addr[$], qb_din[$], qc_addr[$], qc_din[$];
  int qb_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loader u_a (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(rdy_a), .mem_we(we_a), .mem_addr(addr_a),
    .mem_din(din_a), .busy(busy_a), .done(done_a), .overflow(ovf_a), .cpu_hold(hold_a),
    .word_count(wc_a)
  );

  imem_loader #(.BASE_ADDR(32'h0000_0100)) u_b (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(rdy_b), .mem_we(we_b), .mem_addr(addr_b),
    .mem_din(din_b), .busy(busy_b), .done(done_b), .overflow(ovf_b), .cpu_hold(hold_b),
    .word_count(wc_b)
  );

  imem_loader #(.DEPTH(2)) u_c (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(rdy_c), .mem_we(we_c), .mem_addr(addr_c),
    .mem_din(din_c), .busy(busy_c), .done(done_c), .overflow(ovf_c), .cpu_hold(hold_c),
    .word_count(wc_c)
  );

  // Write logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (we_a) begin qa_addr.push_back(addr_a); qa_din.push_back(din_a); end
    if (we_b) begin qb_addr.push_back(addr_b); qb_din.push_back(din_b); qb_cyc.push_back(cyc); end
    if (we_c) begin qc_addr.push_back(addr_c); qc_din.push_back(din_c); end
  end

  task automatic clear_logs();
    qa_addr.delete(); qa_din.delete(); qb_addr.delete(); qb_din.delete(); qb_cyc.delete();
    qc_addr.delete(); qc_din.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = l;
    @(posedge clk);
    #1;
    last_acc   = cyc;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic test_reset();
    idle(2);
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", rdy_a); end
    checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we_a); end
    checks++; if (addr_a !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", addr_a); end
    checks++; if (addr_b !== 32'h100) begin errors++; $display("FAIL reset_addr_b got %h want 100", addr_b); end
    checks++; if (din_a !== 32'h0) begin errors++; $display("FAIL reset_din got %h want 0", din_a); end
    checks++; if (hold_a !== 1'b1) begin errors++; $display("FAIL reset_hold got %b want 1", hold_a); end
    reset = 1'b0;
    idle(2);
    checks++; if ({busy_a, done_a, ovf_a} !== 3'b000) begin errors++; $display("FAIL idle_flags got %b want 000", {busy_a, done_a, ovf_a}); end
    checks++; if (wc_a !== 11'd0) begin errors++; $display("FAIL idle_wc got %0d want 0", wc_a); end
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", rdy_a); end
    // A byte offered while idle must not be taken.
    send_byte(8'h55, 1'b0);
    idle(1);
    checks++; if (qa_addr.size() != 0) begin errors++; $display("FAIL idle_nowrite got %0d writes want 0", qa_addr.size()); end
  endtask

  task automatic test_full_words();
    logic [7:0] img [8];
    img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    clear_logs();
    pulse_start();
    checks++; if ({rdy_a, busy_a, hold_a} !== 3'b111) begin errors++; $display("FAIL load_flags got %b want 111", {rdy_a, busy_a, hold_a}); end
    for (int i = 0; i < 7; i++) send_byte(img[i], 1'b0);
    checks++; if (hold_a !== 1'b1) begin errors++; $display("FAIL hold_before_last got %b want 1", hold_a); end
    send_byte(img[7], 1'b1);
    checks++; if ({we_a, done_a, hold_a} !== 3'b110) begin errors++; $display("FAIL last_cycle we/done/hold got %b want 110", {we_a, done_a, hold_a}); end
    idle(2);
    checks++; if (qa_addr.size() != 2) begin errors++; $display("FAIL full_nwrites got %0d want 2", qa_addr.size()); end
    else begin
      checks++; if (qa_din[0] !== 32'h2008_0005 || qa_addr[0] !== 32'h0) begin errors++; $display("FAIL full_w0 got %h@%h want 20080005@0", qa_din[0], qa_addr[0]); end
      checks++; if (qa_din[1] !== 32'h2009_0007 || qa_addr[1] !== 32'h4) begin errors++; $display("FAIL full_w1 got %h@%h want 20090007@4", qa_din[1], qa_addr[1]); end
    end
    checks++; if (wc_a !== 11'd2) begin errors++; $display("FAIL full_wc got %0d want 2", wc_a); end
    checks++; if ({rdy_a, busy_a, done_a, we_a} !== 4'b0010) begin errors++; $display("FAIL done_flags got %b want 0010", {rdy_a, busy_a, done_a, we_a}); end
    checks++; if (din_a !== 32'h2009_0007) begin errors++; $display("FAIL din_hold got %h want 20090007", din_a); end
  endtask

  task automatic test_partial();
    logic [7:0] img [5];
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    clear_logs();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(img[i], i == 4);
    idle(2);
    checks++; if (qa_addr.size() != 2) begin errors++; $display("FAIL part_nwrites got %0d want 2", qa_addr.size()); end
    else begin
      checks++; if (qa_din[0] !== 32'hAABB_CCDD || qa_addr[0] !== 32'h0) begin errors++; $display("FAIL part_w0 got %h@%h want aabbccdd@0", qa_din[0], qa_addr[0]); end
      checks++; if (qa_din[1] !== 32'hEE00_0000 || qa_addr[1] !== 32'h4) begin errors++; $display("FAIL part_w1 got %h@%h want ee000000@4", qa_din[1], qa_addr[1]); end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] img [4];
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_logs();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(img[i], i == 3);
      if (i < 3) idle(3);
    end
    checks++; if (qb_addr.size() != 0) begin errors++; $display("FAIL gap_early got %0d writes want 0", qb_addr.size()); end
    idle(2);
    checks++; if (qb_addr.size() != 1) begin errors++; $display("FAIL gap_nwrites got %0d want 1", qb_addr.size()); end
    else begin
      checks++; if (qb_din[0] !== 32'h1122_3344 || qb_addr[0] !== 32'h100) begin errors++; $display("FAIL gap_w0 got %h@%h want 11223344@100", qb_din[0], qb_addr[0]); end
      checks++; if (qb_cyc[0] != last_acc) begin errors++; $display("FAIL gap_latency got cycle %0d want %0d", qb_cyc[0], last_acc); end
    end
    checks++; if (addr_b !== 32'h100 || we_b !== 1'b0) begin errors++; $display("FAIL gap_hold got %h we=%b want 100 we=0", addr_b, we_b); end
  endtask

  task automatic test_overflow();
    clear_logs();
    pulse_start();
    for (int i = 1; i <= 12; i++) begin
      send_byte(8'(i), i == 12);
      if (i == 8) begin
        checks++; if (ovf_c !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", ovf_c); end
      end
      if (i == 9) begin
        checks++; if (ovf_c !== 1'b1 || rdy_c !== 1'b1) begin errors++; $display("FAIL ovf_set got ovf=%b rdy=%b want 1 1", ovf_c, rdy_c); end
      end
    end
    idle(2);
    checks++; if (qc_addr.size() != 2) begin errors++; $display("FAIL ovf_nwrites got %0d want 2", qc_addr.size()); end
    else begin
      checks++; if (qc_din[0] !== 32'h0102_0304 || qc_addr[0] !== 32'h0) begin errors++; $display("FAIL ovf_w0 got %h@%h want 01020304@0", qc_din[0], qc_addr[0]); end
      checks++; if (qc_din[1] !== 32'h0506_0708 || qc_addr[1] !== 32'h4) begin errors++; $display("FAIL ovf_w1 got %h@%h want 05060708@4", qc_din[1], qc_addr[1]); end
    end
    checks++; if (wc_c !== 2'd2 || done_c !== 1'b1 || ovf_c !== 1'b1) begin errors++; $display("FAIL ovf_final got wc=%0d done=%b ovf=%b want 2 1 1", wc_c, done_c, ovf_c); end
    checks++; if (ovf_a !== 1'b0 || wc_a !== 11'd3) begin errors++; $display("FAIL deep_noovf got ovf=%b wc=%0d want 0 3", ovf_a, wc_a); end
  endtask

  task automatic test_reset_midload();
    clear_logs();
    pulse_start();
    for (int i = 1; i <= 6; i++) send_byte(8'(8'h30 + i), 1'b0);
    reset = 1'b1;
    #1;
    checks++; if ({rdy_a, we_a, busy_a, done_a, ovf_a, hold_a} !== 6'b000001) begin errors++; $display("FAIL async_flags got %b want 000001", {rdy_a, we_a, busy_a, done_a, ovf_a, hold_a}); end
    checks++; if (addr_a !== 32'h0 || din_a !== 32'h0 || wc_a !== 11'd0) begin errors++; $display("FAIL async_regs got %h %h %0d want 0 0 0", addr_a, din_a, wc_a); end
    idle(2);
    reset = 1'b0;
    idle(2);
    checks++; if (qa_addr.size() != 1) begin errors++; $display("FAIL rst_nwrites got %0d want 1", qa_addr.size()); end
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), i == 3);
    idle(2);
    checks++; if (qa_addr.size() != 2) begin errors++; $display("FAIL rst_reload_n got %0d want 2", qa_addr.size()); end
    else begin
      checks++; if (qa_din[1] !== 32'hA0A1_A2A3 || qa_addr[1] !== 32'h0) begin errors++; $display("FAIL rst_reload got %h@%h want a0a1a2a3@0", qa_din[1], qa_addr[1]); end
    end
  endtask

  task automatic test_restart();
    clear_logs();
    checks++; if (done_a !== 1'b1 || hold_a !== 1'b0) begin errors++; $display("FAIL pre_restart got done=%b hold=%b want 1 0", done_a, hold_a); end
    pulse_start();
    checks++; if ({hold_a, done_a, busy_a} !== 3'b101 || wc_a !== 11'd0) begin errors++; $display("FAIL restart got hdb=%b wc=%0d want 101 0", {hold_a, done_a, busy_a}, wc_a); end
    send_byte(8'hCA, 1'b0);
    send_byte(8'hFE, 1'b0);
    pulse_start();
    checks++; if (busy_a !== 1'b1 || wc_a !== 11'd0) begin errors++; $display("FAIL midstart got busy=%b wc=%0d want 1 0", busy_a, wc_a); end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h0D, 1'b1);
    idle(2);
    checks++; if (qa_addr.size() != 1) begin errors++; $display("FAIL restart_n got %0d want 1", qa_addr.size()); end
    else begin
      checks++; if (qa_din[0] !== 32'hCAFE_F00D || qa_addr[0] !== 32'h0) begin errors++; $display("FAIL restart_w got %h@%h want cafef00d@0", qa_din[0], qa_addr[0]); end
    end
    checks++; if (wc_a !== 11'd1 || done_a !== 1'b1) begin errors++; $display("FAIL restart_end got wc=%0d done=%b want 1 1", wc_a, done_a); end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial();
    test_gaps();
    test_overflow();
    test_reset_midload();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

endmodule
